mem_bus_arbiter: RTL

- Shares the single external memory bus between the instruction-fetch requester (IF) and the data-memory requester (MEM) of the 5-stage pipeline.
- Data requests have priority. A starvation counter guarantees fetch progress.
- Exports im_busy and mem_busy to the pipeline stall/flush controller, which maps them to its `im` and `mem` inputs.
- Sits between the IF/MEM stages and the Wishbone-style bus master port.

---
 rtl/mem_bus_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one Wishbone master port between the fetch and data-memory requesters
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_ack,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  input  logic                    mem_req,
  input  logic                    mem_we,
  input  logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH/8-1:0] mem_sel,
  output logic                    mem_ack,
  output logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    im_busy,
  output logic                    mem_busy,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic                    wb_ack_i
);
  localparam int SW = DATA_WIDTH / 8;
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
  typedef enum logic [1:0] {IDLE, IF_XFER, MEM_XFER, DONE} state_t;
  state_t state_q, state_d;
  logic cyc_q, cyc_d, we_q, we_d, if_ack_q, if_ack_d, mem_ack_q, mem_ack_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d, if_rdata_q, if_rdata_d, mem_rdata_q, mem_rdata_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [3:0] starve_q, starve_d;
  logic grant_mem, grant_if;
  // data wins unless fetch has waited through STARVE_LIMIT data grants
  assign grant_mem = mem_req && (!if_req || starve_q != LIM);
  assign grant_if  = if_req && !grant_mem;
  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = cyc_q;
  assign wb_we_o   = we_q;
  assign wb_adr_o  = adr_q;
  assign wb_dat_o  = dat_q;
  assign wb_sel_o  = sel_q;
  assign if_ack    = if_ack_q;
  assign mem_ack   = mem_ack_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign im_busy   = if_req && !if_ack_q;
  assign mem_busy  = mem_req && !mem_ack_q;
  // next-state: arbitrate in IDLE, hold the bus until acked, pulse the ack from DONE
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    starve_d    = starve_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_mem) begin
          state_d  = MEM_XFER;
          cyc_d    = 1'b1;
          we_d     = mem_we;
          adr_d    = mem_addr;
          dat_d    = mem_wdata;
          sel_d    = mem_sel;
          starve_d = if_req ? (starve_q == LIM ? LIM : starve_q + 4'd1) : 4'd0;
        end else if (grant_if) begin
          state_d  = IF_XFER;
          cyc_d    = 1'b1;
          we_d     = 1'b0;
          adr_d    = if_addr;
          sel_d    = '1;
          starve_d = 4'd0;
        end
      end
      IF_XFER, MEM_XFER: begin
        if (wb_ack_i) begin
          state_d     = DONE;
          cyc_d       = 1'b0;
          if_ack_d    = state_q == IF_XFER;
          mem_ack_d   = state_q == MEM_XFER;
          if_rdata_d  = state_q == IF_XFER ? wb_dat_i : if_rdata_q;
          mem_rdata_d = state_q == MEM_XFER ? wb_dat_i : mem_rdata_q;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state and output registers; reset abandons any bus cycle without acking
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      starve_q    <= 4'd0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      starve_q    <= starve_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end
endmodule
